// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, IR fields, state encoding, decode helpers.
package cpu_ctrl_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned OP_W     = 5;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned STATE_W  = 4;

  // IR field bit positions
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // T3..T7 must stay consecutive: the execute sequencer steps by +1
  typedef enum logic [STATE_W-1:0] {
    S_RST   = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_PAUSE = 4'd9,
    S_HALT  = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU3, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_ST, CL_MFHI, CL_MFLO,
    CL_IN, CL_OUT, CL_JR, CL_JAL, CL_BR, CL_NOP, CL_HALT, CL_UNDEF
  } op_class_t;

  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:           c = CL_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:        c = CL_IMM;
      OP_NEG, OP_NOT:                          c = CL_UNARY;
      OP_MUL, OP_DIV:                          c = CL_MULDIV;
      OP_LD:                                   c = CL_LD;
      OP_ST:                                   c = CL_ST;
      OP_MFHI:                                 c = CL_MFHI;
      OP_MFLO:                                 c = CL_MFLO;
      OP_IN:                                   c = CL_IN;
      OP_OUT:                                  c = CL_OUT;
      OP_JR:                                   c = CL_JR;
      OP_JAL:                                  c = CL_JAL;
      OP_BR:                                   c = CL_BR;
      OP_NOP:                                  c = CL_NOP;
      OP_HALT:                                 c = CL_HALT;
      default:                                 c = CL_UNDEF;
    endcase
    return c;
  endfunction

  // Final execute state of each class; the sequencer returns to T0 after it
  function automatic state_t last_step(input op_class_t cls);
    state_t s;
    case (cls)
      CL_ALU3, CL_IMM:     s = S_T5;
      CL_UNARY, CL_JAL:    s = S_T4;
      CL_MULDIV, CL_BR:    s = S_T6;
      CL_LD, CL_ST:        s = S_T7;
      default:             s = S_T3;
    endcase
    return s;
  endfunction

  // ALU function for the class's ALU step; address and branch-target math use add
  function automatic logic [OP_W-1:0] alu_select(input op_class_t cls, input logic [OP_W-1:0] op);
    logic [OP_W-1:0] f;
    case (cls)
      CL_ALU3, CL_UNARY, CL_MULDIV: f = op;
      CL_IMM: begin
        case (op)
          OP_ANDI: f = OP_AND;
          OP_ORI:  f = OP_OR;
          default: f = OP_ADD;
        endcase
      end
      CL_LD, CL_ST, CL_BR:          f = OP_ADD;
      default:                      f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Maps a 4-bit register field onto a one-hot register-file select vector.
module reg_select_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]    field,
  output logic [NUM_REGS-1:0] onehot
);

  assign onehot = NUM_REGS'(1) << field;

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the 32-bit DataPath: fetch T0-T2, per-class execute T3-T7.
// Optional build macro ILLEGAL_OPCODE_TRAP_EN adds a sticky 'illegal' flag and halts on undefined opcodes.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         IR,
  input  logic                con_ff,
  input  logic                stop,
  output logic                PCout,
  output logic                Zhi_out,
  output logic                Zlo_out,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                Inport_out,
  output logic                Cout,
  output logic [NUM_REGS-1:0] R_out,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                RYin,
  output logic                RZin,
  output logic                HIin,
  output logic                LOin,
  output logic                CONin,
  output logic                Outport_in,
  output logic [NUM_REGS-1:0] R_in,
  output logic                IncPC,
  output logic                Mem_read,
  output logic                Mem_write,
  output logic [OP_W-1:0]     opcode,
  output logic                run
`ifdef ILLEGAL_OPCODE_TRAP_EN
  ,
  output logic                illegal
`endif
);

  state_t                state;
  state_t                state_next;
  op_class_t             cls;
  logic [OP_W-1:0]       alu_op;
  logic [NUM_REGS-1:0]   ra_sel;
  logic [NUM_REGS-1:0]   rb_sel;
  logic [NUM_REGS-1:0]   rc_sel;
  logic                  unused_ir;

  assign cls       = op_class(IR[OP_MSB:OP_LSB]);
  assign alu_op    = alu_select(cls, IR[OP_MSB:OP_LSB]);
  assign unused_ir = ^IR[RC_LSB-1:0];

  reg_select_decode u_ra (.field(IR[RA_MSB:RA_LSB]), .onehot(ra_sel));
  reg_select_decode u_rb (.field(IR[RB_MSB:RB_LSB]), .onehot(rb_sel));
  reg_select_decode u_rc (.field(IR[RC_MSB:RC_LSB]), .onehot(rc_sel));

  // State register; clear wins from any state, including mid-instruction
  always_ff @(posedge clock) begin
    if (!clear) state <= S_RST;
    else        state <= state_next;
  end

  // Next-state sequencing
  always_comb begin
    state_next = state;
    case (state)
      S_RST:   state_next = S_T0;
      S_T0:    state_next = stop ? S_PAUSE : S_T1;
      S_T1:    state_next = S_T2;
      S_T2: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
        state_next = (cls == CL_UNDEF) ? S_HALT : S_T3;
`else
        state_next = S_T3;
`endif
      end
      S_PAUSE: state_next = stop ? S_PAUSE : S_T0;
      S_HALT:  state_next = S_HALT;
      default: begin
        if (state == S_T3 && cls == CL_HALT)  state_next = S_HALT;
        else if (state >= last_step(cls))    state_next = S_T0;
        else                                 state_next = state_t'(state + STATE_W'(1));
      end
    endcase
  end

  // Moore strobe decode from state and IR
  always_comb begin
    PCout      = 1'b0;
    Zhi_out    = 1'b0;
    Zlo_out    = 1'b0;
    MDRout     = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    Inport_out = 1'b0;
    Cout       = 1'b0;
    R_out      = '0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    RYin       = 1'b0;
    RZin       = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    CONin      = 1'b0;
    Outport_in = 1'b0;
    R_in       = '0;
    IncPC      = 1'b0;
    Mem_read   = 1'b0;
    Mem_write  = 1'b0;
    opcode     = '0;
    run        = 1'b1;
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
      end
      S_T1: begin
        Zlo_out = 1'b1; PCin = 1'b1; Mem_read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        case (cls)
          CL_ALU3, CL_IMM, CL_LD, CL_ST: begin R_out = rb_sel; RYin = 1'b1; end
          CL_UNARY:  begin R_out = rb_sel; opcode = alu_op; RZin = 1'b1; end
          CL_MULDIV: begin R_out = ra_sel; RYin = 1'b1; end
          CL_MFHI:   begin HIout = 1'b1; R_in = ra_sel; end
          CL_MFLO:   begin LOout = 1'b1; R_in = ra_sel; end
          CL_IN:     begin Inport_out = 1'b1; R_in = ra_sel; end
          CL_OUT:    begin R_out = ra_sel; Outport_in = 1'b1; end
          CL_JR:     begin R_out = ra_sel; PCin = 1'b1; end
          CL_JAL:    begin PCout = 1'b1; R_in = NUM_REGS'(1) << (NUM_REGS - 1); end
          CL_BR:     begin R_out = ra_sel; CONin = 1'b1; end
          default:   ;
        endcase
      end
      S_T4: begin
        case (cls)
          CL_ALU3:   begin R_out = rc_sel; opcode = alu_op; RZin = 1'b1; end
          CL_IMM, CL_LD, CL_ST: begin Cout = 1'b1; opcode = alu_op; RZin = 1'b1; end
          CL_UNARY:  begin Zlo_out = 1'b1; R_in = ra_sel; end
          CL_MULDIV: begin R_out = rb_sel; opcode = alu_op; RZin = 1'b1; end
          CL_JAL:    begin R_out = ra_sel; PCin = 1'b1; end
          CL_BR:     begin PCout = 1'b1; RYin = 1'b1; end
          default:   ;
        endcase
      end
      S_T5: begin
        case (cls)
          CL_ALU3, CL_IMM: begin Zlo_out = 1'b1; R_in = ra_sel; end
          CL_LD, CL_ST:    begin Zlo_out = 1'b1; MARin = 1'b1; end
          CL_MULDIV:       begin Zlo_out = 1'b1; LOin = 1'b1; end
          CL_BR:           begin Cout = 1'b1; opcode = alu_op; RZin = 1'b1; end
          default:         ;
        endcase
      end
      S_T6: begin
        case (cls)
          CL_LD:     begin Mem_read = 1'b1; MDRin = 1'b1; end
          CL_ST:     begin R_out = ra_sel; MDRin = 1'b1; end
          CL_MULDIV: begin Zhi_out = 1'b1; HIin = 1'b1; end
          CL_BR:     begin Zlo_out = 1'b1; PCin = con_ff; end
          default:   ;
        endcase
      end
      S_T7: begin
        case (cls)
          CL_LD:   begin MDRout = 1'b1; R_in = ra_sel; end
          CL_ST:   Mem_write = 1'b1;
          default: ;
        endcase
      end
      S_PAUSE, S_HALT: run = 1'b0;
      default: ;
    endcase
  end

`ifdef ILLEGAL_OPCODE_TRAP_EN
  // Sticky flag: set on the T2 dispatch of an undefined opcode, cleared only by reset
  always_ff @(posedge clock) begin
    if (!clear)                                  illegal <= 1'b0;
    else if (state == S_T2 && cls == CL_UNDEF)   illegal <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: per-cycle strobe vectors plus pause, mid-instruction clear and halt sequences.
module tb_control_unit;

  localparam logic [7:0] S_PC  = 8'h80;
  localparam logic [7:0] S_ZHI = 8'h40;
  localparam logic [7:0] S_ZLO = 8'h20;
  localparam logic [7:0] S_MDR = 8'h10;
  localparam logic [7:0] S_C   = 8'h01;

  localparam logic [9:0] L_MAR = 10'h200;
  localparam logic [9:0] L_PC  = 10'h100;
  localparam logic [9:0] L_MDR = 10'h080;
  localparam logic [9:0] L_IR  = 10'h040;
  localparam logic [9:0] L_RY  = 10'h020;
  localparam logic [9:0] L_RZ  = 10'h010;
  localparam logic [9:0] L_HI  = 10'h008;
  localparam logic [9:0] L_LO  = 10'h004;
  localparam logic [9:0] L_CON = 10'h002;

  localparam logic [2:0] M_INC = 3'b100;
  localparam logic [2:0] M_RD  = 3'b010;
  localparam logic [2:0] M_WR  = 3'b001;

  localparam logic [31:0] IR_ROR  = 32'h40918000;
  localparam logic [31:0] IR_ROL  = 32'h48918000;
  localparam logic [31:0] IR_LD   = 32'h00900055;
  localparam logic [31:0] IR_ST   = 32'h10900055;
  localparam logic [31:0] IR_MUL  = 32'h83380000;
  localparam logic [31:0] IR_JAL  = 32'hAA800000;
  localparam logic [31:0] IR_BR   = 32'h9A000010;
  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  logic        clock, clear, con_ff, stop;
  logic [31:0] IR;
  logic        PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout;
  logic [15:0] R_out, R_in;
  logic        MARin, PCin, MDRin, IRin, RYin, RZin, HIin, LOin, CONin, Outport_in;
  logic        IncPC, Mem_read, Mem_write, run;
  logic [4:0]  opcode;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic        illegal;
`endif

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Inport_out(Inport_out), .Cout(Cout),
    .R_out(R_out), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .RYin(RYin), .RZin(RZin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
    .Outport_in(Outport_in), .R_in(R_in), .IncPC(IncPC), .Mem_read(Mem_read),
    .Mem_write(Mem_write), .opcode(opcode), .run(run)
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clock = ~clock;

  logic [58:0] obs;
  assign obs = {PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out, Cout,
                R_out,
                MARin, PCin, MDRin, IRin, RYin, RZin, HIin, LOin, CONin, Outport_in,
                R_in, IncPC, Mem_read, Mem_write, opcode, run};

  typedef struct {
    logic [31:0] ir;
    logic        con;
    logic        stp;
    logic [58:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [58:0] ex(input logic [7:0] s, input logic [15:0] ro,
                                     input logic [9:0] l, input logic [15:0] ri,
                                     input logic [2:0] m, input logic [4:0] op,
                                     input logic rn);
    return {s, ro, l, ri, m, op, rn};
  endfunction

  function automatic logic [58:0] ex_t0();
    return ex(S_PC, '0, L_MAR | L_RZ, '0, M_INC, '0, 1'b1);
  endfunction

  task automatic add(input logic [31:0] ir, input logic con, input logic [58:0] e);
    vec_t v;
    v.ir = ir; v.con = con; v.stp = 1'b0; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] ir, input logic con);
    add(ir, con, ex_t0());
    add(ir, con, ex(S_ZLO, '0, L_PC | L_MDR, '0, M_RD, '0, 1'b1));
    add(ir, con, ex(S_MDR, '0, L_IR, '0, '0, '0, 1'b1));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [58:0] e);
    total++;
    if (obs === e) passed++;
    else $display("FAIL %s: got=%h expected=%h (state outputs at t=%0t)", nm, obs, e, $time);
  endtask

  task automatic cyc(input string nm, input logic [58:0] e);
    #1;
    chk(nm, e);
    tick();
  endtask

  initial begin
    clock = 1'b0; clear = 1'b0; IR = '0; con_ff = 1'b0; stop = 1'b0;

    // Per-cycle table, starting in RST after reset is released
    add('0, 1'b0, ex('0, '0, '0, '0, '0, '0, 1'b1));
    fetch(IR_ROR, 1'b0);
    add(IR_ROR, 1'b0, ex('0, 16'h0004, L_RY, '0, '0, '0, 1'b1));
    add(IR_ROR, 1'b0, ex('0, 16'h0008, L_RZ, '0, '0, 5'b01000, 1'b1));
    add(IR_ROR, 1'b0, ex(S_ZLO, '0, '0, 16'h0002, '0, '0, 1'b1));
    fetch(IR_ROL, 1'b0);
    add(IR_ROL, 1'b0, ex('0, 16'h0004, L_RY, '0, '0, '0, 1'b1));
    add(IR_ROL, 1'b0, ex('0, 16'h0008, L_RZ, '0, '0, 5'b01001, 1'b1));
    add(IR_ROL, 1'b0, ex(S_ZLO, '0, '0, 16'h0002, '0, '0, 1'b1));
    fetch(IR_LD, 1'b0);
    add(IR_LD, 1'b0, ex('0, 16'h0004, L_RY, '0, '0, '0, 1'b1));
    add(IR_LD, 1'b0, ex(S_C, '0, L_RZ, '0, '0, 5'b00011, 1'b1));
    add(IR_LD, 1'b0, ex(S_ZLO, '0, L_MAR, '0, '0, '0, 1'b1));
    add(IR_LD, 1'b0, ex('0, '0, L_MDR, '0, M_RD, '0, 1'b1));
    add(IR_LD, 1'b0, ex(S_MDR, '0, '0, 16'h0002, '0, '0, 1'b1));
    fetch(IR_ST, 1'b0);
    add(IR_ST, 1'b0, ex('0, 16'h0004, L_RY, '0, '0, '0, 1'b1));
    add(IR_ST, 1'b0, ex(S_C, '0, L_RZ, '0, '0, 5'b00011, 1'b1));
    add(IR_ST, 1'b0, ex(S_ZLO, '0, L_MAR, '0, '0, '0, 1'b1));
    add(IR_ST, 1'b0, ex('0, 16'h0002, L_MDR, '0, '0, '0, 1'b1));
    add(IR_ST, 1'b0, ex('0, '0, '0, '0, M_WR, '0, 1'b1));
    fetch(IR_MUL, 1'b0);
    add(IR_MUL, 1'b0, ex('0, 16'h0040, L_RY, '0, '0, '0, 1'b1));
    add(IR_MUL, 1'b0, ex('0, 16'h0080, L_RZ, '0, '0, 5'b10000, 1'b1));
    add(IR_MUL, 1'b0, ex(S_ZLO, '0, L_LO, '0, '0, '0, 1'b1));
    add(IR_MUL, 1'b0, ex(S_ZHI, '0, L_HI, '0, '0, '0, 1'b1));
    fetch(IR_JAL, 1'b0);
    add(IR_JAL, 1'b0, ex(S_PC, '0, '0, 16'h8000, '0, '0, 1'b1));
    add(IR_JAL, 1'b0, ex('0, 16'h0020, L_PC, '0, '0, '0, 1'b1));
    fetch(IR_BR, 1'b1);
    add(IR_BR, 1'b1, ex('0, 16'h0010, L_CON, '0, '0, '0, 1'b1));
    add(IR_BR, 1'b1, ex(S_PC, '0, L_RY, '0, '0, '0, 1'b1));
    add(IR_BR, 1'b1, ex(S_C, '0, L_RZ, '0, '0, 5'b00011, 1'b1));
    add(IR_BR, 1'b1, ex(S_ZLO, '0, L_PC, '0, '0, '0, 1'b1));
    fetch(IR_BR, 1'b0);
    add(IR_BR, 1'b0, ex('0, 16'h0010, L_CON, '0, '0, '0, 1'b1));
    add(IR_BR, 1'b0, ex(S_PC, '0, L_RY, '0, '0, '0, 1'b1));
    add(IR_BR, 1'b0, ex(S_C, '0, L_RZ, '0, '0, 5'b00011, 1'b1));
    add(IR_BR, 1'b0, ex(S_ZLO, '0, '0, '0, '0, '0, 1'b1));

    tick();
    tick();
    clear = 1'b1;
    foreach (vecs[i]) begin
      IR = vecs[i].ir; con_ff = vecs[i].con; stop = vecs[i].stp;
      cyc($sformatf("vec%0d_ir%h", i, vecs[i].ir), vecs[i].exp);
    end

    // Pause: stop seen at T0 parks the unit until stop drops
    IR = IR_ADD; con_ff = 1'b0;
    stop = 1'b1;
    cyc("t0_with_stop", ex_t0());
    cyc("pause", ex('0, '0, '0, '0, '0, '0, 1'b0));
    stop = 1'b0;
    cyc("pause_exit", ex('0, '0, '0, '0, '0, '0, 1'b0));
    cyc("t0_resume", ex_t0());
    cyc("t1_resume", ex(S_ZLO, '0, L_PC | L_MDR, '0, M_RD, '0, 1'b1));
    cyc("t2_resume", ex(S_MDR, '0, L_IR, '0, '0, '0, 1'b1));
    cyc("add_t3", ex('0, 16'h0004, L_RY, '0, '0, '0, 1'b1));

    // Clear held low across two edges starting mid-T4 of an add
    clear = 1'b0;
    cyc("add_t4", ex('0, 16'h0008, L_RZ, '0, '0, 5'b00011, 1'b1));
    cyc("clr_rst_a", ex('0, '0, '0, '0, '0, '0, 1'b1));
    clear = 1'b1;
    cyc("clr_rst_b", ex('0, '0, '0, '0, '0, '0, 1'b1));
    cyc("clr_t0", ex_t0());

    // Halt: parks with run low until reset
    IR = IR_HALT;
    cyc("halt_t1", ex(S_ZLO, '0, L_PC | L_MDR, '0, M_RD, '0, 1'b1));
    cyc("halt_t2", ex(S_MDR, '0, L_IR, '0, '0, '0, 1'b1));
    cyc("halt_t3", ex('0, '0, '0, '0, '0, '0, 1'b1));
    for (int k = 0; k < 20; k++) begin
      stop = k[0];
      cyc($sformatf("halt_hold%0d", k), ex('0, '0, '0, '0, '0, '0, 1'b0));
    end
    stop = 1'b0;
    clear = 1'b0;
    cyc("halt_clear", ex('0, '0, '0, '0, '0, '0, 1'b0));
    clear = 1'b1;
    cyc("rst_after_halt", ex('0, '0, '0, '0, '0, '0, 1'b1));
    cyc("t0_after_halt", ex_t0());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
